fetch_stage: RTL

//  Instruction-fetch stage: owns the PC, drives the instruction memory, and reports ihit to hazard_unit.

---
 rtl/fetch_stage_pkg.sv | 8 +
 rtl/fetch_stage_if.sv | 28 ++
 rtl/fetch_stage_hold_buffer.sv | 31 +++
 rtl/fetch_stage.sv | 90 +++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// cpu_types_pkg: shared word, next-PC select and fetch state types for the fetch stage.
package cpu_types_pkg;
    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;
    typedef enum logic [1:0] {PC_SEQ = 2'd0, PC_JR = 2'd1, PC_J = 2'd2, PC_BR = 2'd3} pcsel_t;
    typedef enum logic [1:0] {IDLE, FETCH, HELD, HALTED} fetch_state_t;
    localparam word_t NOP_INSTR = 32'h0;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: hazard-unit controls, instruction memory port and IF/ID outputs of the fetch stage.
interface fetch_stage_if;
    import cpu_types_pkg::*;
    logic   pcen;
    pcsel_t PCSel;
    logic   deen;
    logic   deflush;
    logic   halt;
    word_t  jr_target;
    logic [25:0] jaddr;
    word_t  br_target;
    logic   imem_ren;
    word_t  imem_addr;
    logic   imem_wait;
    word_t  imem_load;
    logic   ihit;
    word_t  if_instr;
    word_t  if_npc;
    logic   if_valid;
    modport master (
        output pcen, PCSel, deen, deflush, halt, jr_target, jaddr, br_target, imem_wait, imem_load,
        input  imem_ren, imem_addr, ihit, if_instr, if_npc, if_valid
    );
    modport slave (
        input  pcen, PCSel, deen, deflush, halt, jr_target, jaddr, br_target, imem_wait, imem_load,
        output imem_ren, imem_addr, ihit, if_instr, if_npc, if_valid
    );
endinterface

// File: rtl/fetch_stage_hold_buffer.sv
// fetch_hold_buffer: one-entry instruction hold register with the ihit/fetch-word select.
module fetch_hold_buffer
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  i_fetch,
    input  logic  i_held,
    input  logic  i_wait,
    input  logic  i_capture,
    input  logic  i_clear,
    input  word_t i_load,
    output logic  o_ihit,
    output word_t o_word
);
    word_t r_data;
    logic  r_v;
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_v    <= 1'b0;
            r_data <= NOP_INSTR;
        end else if (i_clear) begin
            r_v <= 1'b0;
        end else if (i_capture) begin
            r_v    <= 1'b1;
            r_data <= i_load;
        end
    end
    assign o_ihit = i_held ? r_v : (i_fetch & ~i_wait);
    assign o_word = i_held ? r_data : i_load;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, drives instruction memory, holds stalled words and the IF/ID latch.
// FETCH_PERF_CNT_EN adds saturating fetch/stall performance counters.
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t RESET_PC = 32'h0000_0000
)(
    input  logic CLK,
    input  logic nRST,
    fetch_stage_if.slave bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output word_t perf_fetch_cnt,
    output word_t perf_stall_cnt
`endif
);
    fetch_state_t r_state, w_state_nxt;
    word_t r_pc, r_instr, r_npc, w_npc, w_pc_nxt, w_word;
    logic  r_valid, w_fetch, w_held, w_halted, w_ihit, w_upd, w_load, w_ren;
    assign w_fetch  = (r_state == FETCH);
    assign w_held   = (r_state == HELD);
    assign w_halted = (r_state == HALTED);
    assign w_npc    = r_pc + 32'd4;
    assign w_upd    = bus.pcen & (w_fetch | w_held);
    assign w_load   = ~bus.deflush & bus.deen & w_ihit;
    assign w_pc_nxt = (bus.PCSel == PC_JR) ? bus.jr_target :
                      (bus.PCSel == PC_J)  ? {w_npc[31:28], bus.jaddr, 2'b00} :
                      (bus.PCSel == PC_BR) ? bus.br_target : w_npc;
    fetch_hold_buffer u_hold (
        .CLK       (CLK),
        .nRST      (nRST),
        .i_fetch   (w_fetch),
        .i_held    (w_held),
        .i_wait    (bus.imem_wait),
        .i_capture (w_fetch & w_ihit & ~bus.pcen & ~bus.halt),
        .i_clear   (bus.pcen | bus.halt),
        .i_load    (bus.imem_load),
        .o_ihit    (w_ihit),
        .o_word    (w_word)
    );
    always_comb begin
        w_state_nxt = r_state;
        w_ren       = w_fetch;
        if (bus.halt) w_state_nxt = HALTED;
        else if (r_state == IDLE) w_state_nxt = FETCH;
        else if (w_fetch && w_ihit && !bus.pcen) w_state_nxt = HELD;
        else if (w_held && bus.pcen) w_state_nxt = FETCH;
    end
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
            r_instr <= NOP_INSTR;
            r_npc   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_upd) r_pc <= w_pc_nxt;
            // a flush still lands on the edge that enters HALTED, but never after
            if (!w_halted && bus.deflush) begin
                r_instr <= NOP_INSTR;
                r_valid <= 1'b0;
            end else if (!w_halted && w_load) begin
                r_instr <= w_word;
                r_npc   <= w_npc;
                r_valid <= 1'b1;
            end
        end
    end
    assign bus.imem_ren  = w_ren;
    assign bus.imem_addr = r_pc;
    assign bus.ihit      = w_ihit;
    assign bus.if_instr  = r_instr;
    assign bus.if_npc    = r_npc;
    assign bus.if_valid  = r_valid;
`ifdef FETCH_PERF_CNT_EN
    word_t r_fetch_cnt, r_stall_cnt;
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else if (!w_halted) begin
            if (w_load && r_fetch_cnt != '1) r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (w_fetch && bus.imem_wait && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end
    assign perf_fetch_cnt = r_fetch_cnt;
    assign perf_stall_cnt = r_stall_cnt;
`endif
endmodule
